// File: rtl/timer_scheduler.sv
// Countdown sequencer for the anti-theft Timer: owns the four interval
// parameters, issues load pulses and forwards only expiries the FSM requested.
module timer_scheduler #(
  parameter logic [3:0] DEF_ARM_DELAY  = 4'd6,
  parameter logic [3:0] DEF_DRV_DELAY  = 4'd8,
  parameter logic [3:0] DEF_PASS_DELAY = 4'd15,
  parameter logic [3:0] DEF_ALARM_ON   = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_start,
  input  logic [1:0] req_interval,
  input  logic       req_cancel,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       expired_in,
  output logic [3:0] value,
  output logic       start_timer,
  output logic       expired_out,
  output logic       busy,
  output logic       prog_ack,
  output logic       prog_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_PROG = 3'd4
  } state_e;

  state_e     state_q;
  logic [3:0] table_q [4];
  logic [3:0] value_q;
  logic       start_q;
  logic       expired_q;
  logic       busy_q;
  logic       ack_q;
  logic       err_q;
  logic       reprog_prev_q;
  logic       reprog_rise_d;

  assign reprog_rise_d = reprogram & ~reprog_prev_q;

  // Single-process FSM; every output is a register set on the transition into its state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      table_q[0]    <= DEF_ARM_DELAY;
      table_q[1]    <= DEF_DRV_DELAY;
      table_q[2]    <= DEF_PASS_DELAY;
      table_q[3]    <= DEF_ALARM_ON;
      value_q       <= 4'd0;
      start_q       <= 1'b0;
      expired_q     <= 1'b0;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      reprog_prev_q <= 1'b0;
    end else begin
      reprog_prev_q <= reprogram;
      start_q       <= 1'b0;
      expired_q     <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (reprog_rise_d) begin
            state_q <= S_PROG;
            busy_q  <= 1'b0;
            if (time_value != 4'd0) begin
              table_q[time_param_sel] <= time_value;
              ack_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (req_start) begin
            state_q <= S_LOAD;
            value_q <= table_q[req_interval];
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
        end
        // Abandoning the countdown (reprogram/cancel/restart) must never leak an expiry.
        S_RUN: begin
          if (reprog_rise_d) begin
            state_q <= S_PROG;
            busy_q  <= 1'b0;
            if (time_value != 4'd0) begin
              table_q[time_param_sel] <= time_value;
              ack_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (req_cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (req_start) begin
            state_q <= S_LOAD;
            value_q <= table_q[req_interval];
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (expired_in) begin
            state_q   <= S_DONE;
            expired_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_PROG: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign value       = value_q;
  assign start_timer = start_q;
  assign expired_out = expired_q;
  assign busy        = busy_q;
  assign prog_ack    = ack_q;
  assign prog_err    = err_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: directed scenarios plus a random
// run checked against an output-driven reference model.
module tb_timer_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_start;
  logic [1:0] req_interval;
  logic       req_cancel;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired_in;
  logic [3:0] value;
  logic       start_timer;
  logic       expired_out;
  logic       busy;
  logic       prog_ack;
  logic       prog_err;

  int n_cmp  = 0;
  int n_fail = 0;

  timer_scheduler dut (
    .clock(clock), .reset(reset), .req_start(req_start), .req_interval(req_interval),
    .req_cancel(req_cancel), .reprogram(reprogram), .time_param_sel(time_param_sel),
    .time_value(time_value), .expired_in(expired_in), .value(value),
    .start_timer(start_timer), .expired_out(expired_out), .busy(busy),
    .prog_ack(prog_ack), .prog_err(prog_err)
  );

  always #5 clock = ~clock;

  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_start = 1'b0; req_interval = 2'd0; req_cancel = 1'b0;
    reprogram = 1'b0; time_param_sel = 2'd0; time_value = 4'd0; expired_in = 1'b0;
    clk1(); clk1();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({value, start_timer, expired_out, busy, prog_ack, prog_err} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000000",
               {value, start_timer, expired_out, busy, prog_ack, prog_err});
    end
  endtask

  task automatic test_basic();
    int exp_cnt;
    req_start = 1'b1; req_interval = 2'b10;
    clk1();
    req_start = 1'b0;
    n_cmp++;
    if ({start_timer, busy, value} !== {1'b1, 1'b1, 4'd15}) begin
      n_fail++;
      $display("FAIL basic_load: got start=%b busy=%b value=%0d want 1 1 15", start_timer, busy, value);
    end
    clk1(); clk1();
    expired_in = 1'b1;
    clk1();
    expired_in = 1'b0;
    n_cmp++;
    if ({expired_out, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_expire: got expired=%b busy=%b want 1 0", expired_out, busy);
    end
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      clk1();
      exp_cnt += int'(expired_out) + int'(busy);
    end
    n_cmp++;
    if (exp_cnt != 0) begin
      n_fail++;
      $display("FAIL basic_after: got %0d high expired/busy samples want 0", exp_cnt);
    end
  endtask

  task automatic test_prog_err();
    time_param_sel = 2'b01; time_value = 4'd0; reprogram = 1'b1;
    clk1();
    n_cmp++;
    if ({prog_err, prog_ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL prog_err_pulse: got err=%b ack=%b want 1 0", prog_err, prog_ack);
    end
    reprogram = 1'b0;
    clk1();
    req_start = 1'b1; req_interval = 2'b01;
    clk1();
    req_start = 1'b0;
    n_cmp++;
    if ({start_timer, value} !== {1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL prog_err_table: got start=%b value=%0d want 1 8", start_timer, value);
    end
    clk1();
    req_cancel = 1'b1;
    clk1();
    req_cancel = 1'b0;
  endtask

  task automatic test_prog_ack();
    int ack_cnt;
    time_param_sel = 2'b01; time_value = 4'd4; reprogram = 1'b1;
    clk1();
    n_cmp++;
    if ({prog_ack, prog_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL prog_ack_pulse: got ack=%b err=%b want 1 0", prog_ack, prog_err);
    end
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      clk1();
      ack_cnt += int'(prog_ack);
    end
    n_cmp++;
    if (ack_cnt != 0) begin
      n_fail++;
      $display("FAIL prog_level_once: got %0d extra acks want 0", ack_cnt);
    end
    reprogram = 1'b0;
    req_start = 1'b1; req_interval = 2'b01;
    clk1();
    req_start = 1'b0;
    n_cmp++;
    if ({start_timer, value} !== {1'b1, 4'd4}) begin
      n_fail++;
      $display("FAIL prog_new_value: got start=%b value=%0d want 1 4", start_timer, value);
    end
    clk1();
    req_cancel = 1'b1;
    clk1();
    req_cancel = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_restart();
    int exp_cnt;
    req_start = 1'b1; req_interval = 2'b00;
    clk1();
    req_start = 1'b0;
    n_cmp++;
    if ({start_timer, value} !== {1'b1, 4'd6}) begin
      n_fail++;
      $display("FAIL restart_first: got start=%b value=%0d want 1 6", start_timer, value);
    end
    clk1(); clk1();
    req_start = 1'b1; req_interval = 2'b11;
    clk1();
    req_start = 1'b0;
    n_cmp++;
    if ({start_timer, value} !== {1'b1, 4'd10}) begin
      n_fail++;
      $display("FAIL restart_second: got start=%b value=%0d want 1 10", start_timer, value);
    end
    clk1();
    expired_in = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      clk1();
      expired_in = 1'b0;
      exp_cnt += int'(expired_out);
    end
    n_cmp++;
    if (exp_cnt != 1) begin
      n_fail++;
      $display("FAIL restart_single_expiry: got %0d pulses want 1", exp_cnt);
    end
  endtask

  task automatic test_cancel();
    req_start = 1'b1; req_interval = 2'b10;
    clk1();
    req_start = 1'b0;
    clk1();
    req_cancel = 1'b1;
    clk1();
    req_cancel = 1'b0;
    expired_in = 1'b1;
    clk1();
    expired_in = 1'b0;
    n_cmp++;
    if ({expired_out, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL cancel_no_expiry: got expired=%b busy=%b want 0 0", expired_out, busy);
    end
    req_start = 1'b1; req_interval = 2'b00;
    clk1();
    req_start = 1'b0;
    n_cmp++;
    if (start_timer !== 1'b1) begin
      n_fail++;
      $display("FAIL cancel_idle: got start=%b want 1", start_timer);
    end
    clk1();
    req_cancel = 1'b1;
    clk1();
    req_cancel = 1'b0;
  endtask

  task automatic test_collision_and_reset();
    logic [3:0] defs [4];
    defs[0] = 4'd6; defs[1] = 4'd8; defs[2] = 4'd15; defs[3] = 4'd10;
    time_param_sel = 2'b11; time_value = 4'd9;
    reprogram = 1'b1; req_start = 1'b1; req_interval = 2'b10;
    clk1();
    req_start = 1'b0;
    n_cmp++;
    if ({prog_ack, start_timer} !== 2'b10) begin
      n_fail++;
      $display("FAIL collision: got ack=%b start=%b want 1 0", prog_ack, start_timer);
    end
    clk1();
    reprogram = 1'b0;
    n_cmp++;
    if ({start_timer, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL collision_dropped: got start=%b busy=%b want 0 0", start_timer, busy);
    end
    req_start = 1'b1; req_interval = 2'b11;
    clk1();
    req_start = 1'b0;
    n_cmp++;
    if (value !== 4'd9) begin
      n_fail++;
      $display("FAIL collision_write: got value=%0d want 9", value);
    end
    clk1(); clk1();
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    n_cmp++;
    if ({value, start_timer, expired_out, busy, prog_ack, prog_err} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %b want 000000000",
               {value, start_timer, expired_out, busy, prog_ack, prog_err});
    end
    for (int i = 0; i < 4; i++) begin
      req_start = 1'b1; req_interval = 2'(i);
      clk1();
      req_start = 1'b0;
      n_cmp++;
      if (value !== defs[i]) begin
        n_fail++;
        $display("FAIL reset_table[%0d]: got %0d want %0d", i, value, defs[i]);
      end
      clk1();
      req_cancel = 1'b1;
      clk1();
      req_cancel = 1'b0;
    end
  endtask

  // Model phase is inferred from the expected outputs alone:
  // start=load, expired=done, ack/err=prog, busy without start=run, all low=idle.
  task automatic test_random();
    logic [3:0] m_tab [4];
    logic [3:0] m_val;
    logic m_start, m_exp, m_busy, m_ack, m_err, m_prev, rise, running, idle;
    logic n_start, n_exp, n_busy, n_ack, n_err;
    do_reset();
    m_tab[0] = 4'd6; m_tab[1] = 4'd8; m_tab[2] = 4'd15; m_tab[3] = 4'd10;
    m_val = 4'd0; m_prev = 1'b0;
    {m_start, m_exp, m_busy, m_ack, m_err} = 5'd0;
    for (int c = 0; c < 2000; c++) begin
      req_start      = ($urandom_range(0, 5) == 0);
      req_interval   = 2'($urandom_range(0, 3));
      req_cancel     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) reprogram = ~reprogram;
      time_param_sel = 2'($urandom_range(0, 3));
      time_value     = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      expired_in     = ($urandom_range(0, 4) == 0);
      rise    = reprogram && !m_prev;
      running = m_busy && !m_start;
      idle    = !m_busy && !m_exp && !m_ack && !m_err;
      {n_start, n_exp, n_busy, n_ack, n_err} = 5'd0;
      if (m_start) begin
        n_busy = 1'b1;
      end else if (idle || running) begin
        if (rise) begin
          if (time_value != 4'd0) begin
            m_tab[time_param_sel] = time_value;
            n_ack = 1'b1;
          end else begin
            n_err = 1'b1;
          end
        end else if (running && req_cancel) begin
          n_busy = 1'b0;
        end else if (req_start) begin
          n_start = 1'b1; n_busy = 1'b1; m_val = m_tab[req_interval];
        end else if (running && expired_in) begin
          n_exp = 1'b1;
        end else begin
          n_busy = running;
        end
      end
      m_prev = reprogram;
      {m_start, m_exp, m_busy, m_ack, m_err} = {n_start, n_exp, n_busy, n_ack, n_err};
      clk1();
      n_cmp++;
      if ({value, start_timer, expired_out, busy, prog_ack, prog_err} !==
          {m_val, m_start, m_exp, m_busy, m_ack, m_err}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got v=%0d s=%b e=%b b=%b a=%b r=%b want v=%0d s=%b e=%b b=%b a=%b r=%b",
                 c, value, start_timer, expired_out, busy, prog_ack, prog_err,
                 m_val, m_start, m_exp, m_busy, m_ack, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prog_err();
    test_prog_ack();
    test_restart();
    test_cancel();
    test_collision_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
